// File: rtl/lookup_arbiter.sv
// lookup_arbiter: round-robin arbiter sharing one combinational addr->data
// lookup path among NUM_REQ valid/ready requesters, one lookup in flight.
// Optional completed-transaction counter (txn_count) under LOOKUP_ARB_STATS_EN.
module lookup_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_data
`ifdef LOOKUP_ARB_STATS_EN
    ,
    output logic [15:0]               txn_count
`endif
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [ADDR_W-1:0]  win_addr;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic               accept;
    logic               rsp_done;

    // Rotating-priority search: first valid requester at or after rr_ptr
    always_comb begin
        int unsigned cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_valid[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // Address of the winning requester
    always_comb begin
        win_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign accept   = (state_q == IDLE) && win_found;
    assign rsp_done = (state_q == RESP) && rsp_ready[grant_q];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_ready[grant_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake strobes: accept in IDLE, response valid while in RESP
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
        if (state_q == RESP) begin
            rsp_valid[grant_q] = 1'b1;
        end
    end

    // Captured request, grant, round-robin pointer and lookup result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr  <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= win_addr;
                grant_q <= win_idx;
                rr_ptr  <= (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
            end
            if (state_q == ISSUE) begin
                data_q <= mem_data;
            end
        end
    end

    assign mem_addr = addr_q;
    assign rsp_data = data_q;

`ifdef LOOKUP_ARB_STATS_EN
    // Saturating count of completed responses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txn_count <= '0;
        end else if (rsp_done && (txn_count != 16'hFFFF)) begin
            txn_count <= txn_count + 16'd1;
        end
    end
`else
    logic unused_done;
    assign unused_done = rsp_done;
`endif

endmodule

// File: tb/tb_lookup_arbiter.sv
// tb_lookup_arbiter: scoreboard bench for lookup_arbiter. A transaction-level
// model predicts grants and pushes expected responses; a monitor pops and
// compares them against the DUT response channel.
module tb_lookup_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [N-1:0]    rsp_ready;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
`ifdef LOOKUP_ARB_STATS_EN
    logic [15:0]     txn_count;
`endif

    lookup_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
`ifdef LOOKUP_ARB_STATS_EN
        ,
        .txn_count (txn_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lookup path: identity or a byte-swap scramble
    logic ident;
    function automatic logic [15:0] scramble(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hA5C3;
    endfunction
    assign mem_data = ident ? mem_addr : scramble(mem_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          idx;
        logic [15:0] data;
        int          acc;
    } txn_t;

    txn_t        sb[$];
    int          grant_log[$];
    int          cyc = 0;
    int          ptr = 0;
    bit          busy = 0;
    logic [15:0] exp_maddr = '0;

    // Reference model: rotating priority, one transaction at a time
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int           c;
        cyc++;
        if (!reset) begin
            ptr       = 0;
            busy      = 0;
            exp_maddr = '0;
            sb.delete();
        end else begin
            exp_rdy = '0;
            chk("mem_addr", 32'(mem_addr), 32'(exp_maddr));
            if (!busy) begin
                for (int k = 0; k < N; k++) begin
                    c = (ptr + k) % N;
                    if (req_valid[c] && exp_rdy == '0) begin
                        txn_t t;
                        logic [15:0] a;
                        a         = req_addr[c*AW +: AW];
                        exp_rdy[c] = 1'b1;
                        t.idx     = c;
                        t.data    = ident ? a : scramble(a);
                        t.acc     = cyc;
                        sb.push_back(t);
                        grant_log.push_back(c);
                        ptr       = (c + 1) % N;
                        busy      = 1;
                        exp_maddr = a;
                    end
                end
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        end
    end

    txn_t        cur;
    bit          cur_active = 0;
    int unsigned exp_cnt = 0;

    // Response monitor: pops expected responses and checks the response channel
    always @(negedge clk) begin
        logic [N-1:0] oh;
        #2;
        if (!reset) begin
            cur_active = 0;
            exp_cnt    = 0;
            chk("rsp_valid_rst", 32'(rsp_valid), 32'h0);
            chk("rsp_data_rst", 32'(rsp_data), 32'h0);
        end else begin
`ifdef LOOKUP_ARB_STATS_EN
            chk("txn_count", 32'(txn_count), 32'(exp_cnt));
`endif
            if (!cur_active) begin
                if (rsp_valid != '0) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
                    end else begin
                        cur = sb.pop_front();
                        cur_active = 1;
                        chk("rsp_latency", 32'(cyc - cur.acc), 32'd2);
                    end
                end else begin
                    chk("rsp_idle", 32'(rsp_valid), 32'h0);
                    if (sb.size() > 0 && cyc > sb[0].acc + 2) begin
                        chk("rsp_timeout", 32'(cyc - sb[0].acc), 32'd2);
                        void'(sb.pop_front());
                        busy = 0;
                    end
                end
            end
            if (cur_active) begin
                oh = '0;
                oh[cur.idx] = 1'b1;
                chk("rsp_valid", 32'(rsp_valid), 32'(oh));
                chk("rsp_data", 32'(rsp_data), 32'(cur.data));
                if (rsp_ready[cur.idx]) begin
                    cur_active = 0;
                    busy       = 0;
                    if (exp_cnt < 32'hFFFF) exp_cnt++;
                end
            end
        end
    end

    // Stimulus side: per-requester pending requests held until accepted
    logic [N-1:0] pend_v = '0;
    logic [15:0]  pend_a [N];
    logic [N-1:0] renew = '0;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend_v[i];
            req_addr[i*AW +: AW]  = pend_a[i];
        end
    endtask

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        #3;
        acc = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) pend_v[i] = renew[i];
        end
        drive();
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (pend_v == '0 && !busy && !cur_active && sb.size() == 0) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout busy=%0d pend=%b expected idle", busy, pend_v);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        int base;
        reset     = 1'b0;
        ident     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) pend_a[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Idle after reset: everything stays zero
        repeat (5) step();
        chk("idle_mem_addr", 32'(mem_addr), 32'h0);
        chk("idle_rsp_data", 32'(rsp_data), 32'h0);
        chk("idle_req_ready", 32'(req_ready), 32'h0);

        // Single request, identity lookup
        pend_a[0] = 16'h1234;
        pend_v[0] = 1'b1;
        drive();
        wait_idle(50);
        chk("single_grant", 32'(grant_log[$]), 32'd0);

        // All requesters valid: grants rotate 0,1,2,3,0
        do_reset();
        base = grant_log.size();
        renew = '1;
        for (int i = 0; i < N; i++) begin
            pend_a[i] = 16'(16 * (i + 1));
            pend_v[i] = 1'b1;
        end
        drive();
        for (int n = 0; n < 100 && grant_log.size() < base + 5; n++) step();
        renew  = '0;
        pend_v = '0;
        drive();
        wait_idle(50);
        chk("rot_count", 32'(grant_log.size() - base), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (base + k < grant_log.size())
                chk("rot_order", 32'(grant_log[base + k]), 32'(k % N));
        end

        // Response stall on requester 2 while requester 0 waits
        rsp_ready = 4'b1011;
        pend_a[2] = 16'hBEEF;
        pend_v[2] = 1'b1;
        drive();
        for (int n = 0; n < 20 && pend_v[2]; n++) step();
        pend_a[0] = 16'h0777;
        pend_v[0] = 1'b1;
        drive();
        repeat (10) step();
        chk("stall_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("stall_rsp_data", 32'(rsp_data), 32'hBEEF);
        chk("stall_req0_pending", 32'(pend_v[0]), 32'h1);
        rsp_ready = '1;
        drive();
        wait_idle(50);
        chk("after_stall_prev", 32'(grant_log[grant_log.size() - 2]), 32'd2);
        chk("after_stall_next", 32'(grant_log[$]), 32'd0);

        // Reset during ISSUE of requester 1
        pend_a[1] = 16'h00AA;
        pend_v[1] = 1'b1;
        drive();
        step();
        chk("issue_grant", 32'(grant_log[$]), 32'd1);
        chk("issue_pend_clear", 32'(pend_v[1]), 32'h0);
        reset = 1'b0;
        #1;
        chk("async_req_ready", 32'(req_ready), 32'h0);
        chk("async_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("async_rsp_data", 32'(rsp_data), 32'h0);
        chk("async_mem_addr", 32'(mem_addr), 32'h0);
        step();
        step();
        reset = 1'b1;
        repeat (5) step();
        pend_a[1] = 16'h0101;
        pend_a[3] = 16'h0303;
        pend_v[1] = 1'b1;
        pend_v[3] = 1'b1;
        drive();
        wait_idle(50);
        chk("post_rst_first", 32'(grant_log[grant_log.size() - 2]), 32'd1);
        chk("post_rst_second", 32'(grant_log[$]), 32'd3);

        // Randomized traffic with scrambled lookup and random response backpressure
        ident = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(2) == 0) begin
                    pend_a[i] = 16'($urandom);
                    pend_v[i] = 1'b1;
                end
            end
            rsp_ready = 4'($urandom);
            drive();
        end
        rsp_ready = '1;
        drive();
        wait_idle(200);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
